// File: rtl/uart_la_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_la_pkg
// Description : Shared types, defaults and helpers for the logic analyzer's
//               UART channel (state encodings, default sizes, log2 helper).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_la_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Smallest r such that 2**r >= value (value >= 1)
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with synchronous
//               flush. Head entry is presented combinationally on pop_data.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import uart_la_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int ADDR_W = log2_ceil(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              valid,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_DEPTH = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_eff;
  logic              push_eff;

  assign valid    = (count != '0);
  assign full     = (count == CNT_DEPTH);
  // A pop while empty is a no-op; a push while full is only accepted
  // when the head leaves in the same cycle.
  assign pop_eff  = pop && valid;
  assign push_eff = push && (!full || pop_eff);
  // Gate the head so an empty FIFO always shows zero data
  assign pop_data = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy tracking; flush wins over push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_eff)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_capture_buffer
// Description : Trigger/capture stage for decoded UART bytes. Optionally
//               waits for a trigger byte, then stores capture_len bytes
//               (0 = unlimited) into a FWFT FIFO drained by the host.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_capture_buffer
  import uart_la_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int ADDR_W = log2_ceil(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_byte,
  input  logic [ADDR_W:0]   capture_len,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        state_o,
  output logic              triggered,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] trig_byte_q;
  logic [ADDR_W:0]   capture_len_q;
  logic [ADDR_W:0]   byte_cnt;

  logic              fifo_flush;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              cnt_inc;
  logic              trig_hit;
  logic              len_hit;
  logic              drop;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (rd_data),
    .valid     (rd_valid),
    .count     (count),
    .full      (fifo_full)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode: arm beats abort, abort beats normal progress
  always_comb begin
    state_next = state;
    if (arm) begin
      state_next = trig_en ? ST_ARMED : ST_CAPTURE;
    end else if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_ARMED:   if (trig_hit) state_next = (capture_len_q == CNT_ONE) ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE: if (len_hit)  state_next = ST_DONE;
        default:    state_next = state;
      endcase
    end
  end

  // Output decode: FIFO controls and flag-update strobes per state
  always_comb begin
    fifo_flush = arm;
    fifo_pop   = rd_ready && !arm;
    fifo_push  = 1'b0;
    cnt_inc    = 1'b0;
    trig_hit   = 1'b0;
    len_hit    = 1'b0;
    drop       = 1'b0;
    if (!arm && !abort && in_valid) begin
      case (state)
        ST_ARMED: begin
          if (in_data == trig_byte_q) begin
            trig_hit  = 1'b1;
            fifo_push = 1'b1;
          end
        end
        ST_CAPTURE: begin
          cnt_inc = 1'b1;
          // Full FIFO still accepts the byte if the head pops this cycle
          if (!fifo_full || (rd_valid && rd_ready)) fifo_push = 1'b1;
          else                                      drop      = 1'b1;
          len_hit = (capture_len_q != '0) && ((byte_cnt + CNT_ONE) == capture_len_q);
        end
        default: ;
      endcase
    end
  end

  // Sticky flags, byte counter and configuration latched on arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      triggered     <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      byte_cnt      <= '0;
      trig_byte_q   <= '0;
      capture_len_q <= '0;
    end else if (arm) begin
      triggered     <= !trig_en;
      done          <= 1'b0;
      overflow      <= 1'b0;
      byte_cnt      <= '0;
      trig_byte_q   <= trig_byte;
      capture_len_q <= capture_len;
    end else begin
      if (trig_hit) begin
        triggered <= 1'b1;
        byte_cnt  <= CNT_ONE;
        if (capture_len_q == CNT_ONE) done <= 1'b1;
      end
      if (cnt_inc) byte_cnt <= byte_cnt + CNT_ONE;
      if (len_hit) done     <= 1'b1;
      if (drop)    overflow <= 1'b1;
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire
